// File: rtl/alu_shift_seq.sv
// Multi-count shift/rotate sequencer for x86 group-2 opcodes.
// It steps an external single-bit combinational ALU once per clock and tracks CF/OF itself.
module alu_shift_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic        bit16,
  input  logic [15:0] operand,
  input  logic [7:0]  count,
  input  logic        cf_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cf_out,
  output logic        of_out,
  output logic        flags_we,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic        alu_bit16,
  output logic        alu_cf,
  input  logic [15:0] alu_res
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  state;
  logic [2:0]  mode_r;
  logic        bit16_r;
  logic [15:0] acc;
  logic        cf;
  logic [4:0]  cnt;

  logic [15:0] operand_m;
  logic        count_zero;
  logic [15:0] step_acc;
  logic        old_msb;
  logic        new_msb;
  logic        new_msb1;
  logic        step_cf;
  logic        step_of;

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign alu_op    = {1'b1, mode_r};
  assign alu_a     = acc;
  assign alu_bit16 = bit16_r;
  assign alu_cf    = cf;

  assign operand_m  = bit16 ? operand : {8'h00, operand[7:0]};
  assign count_zero = ((count & 8'h1F) == 8'h00);

  // One ALU step: the carry is the bit shifted out of the old value, OF is judged on the new one.
  always_comb begin
    step_acc = bit16_r ? alu_res : {8'h00, alu_res[7:0]};
    old_msb  = bit16_r ? acc[15] : acc[7];
    new_msb  = bit16_r ? step_acc[15] : step_acc[7];
    new_msb1 = bit16_r ? step_acc[14] : step_acc[6];
    step_cf  = mode_r[0] ? acc[0] : old_msb;
    step_of  = 1'b0;
    case (mode_r)
      3'd0, 3'd2, 3'd4, 3'd6: step_of = new_msb ^ step_cf;
      3'd1, 3'd3:             step_of = new_msb ^ new_msb1;
      3'd5:                   step_of = old_msb;
      default:                step_of = 1'b0;
    endcase
  end

  // Writeback values are loaded on the edge entering FIN and then held until the next load.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      mode_r   <= 3'd0;
      bit16_r  <= 1'b0;
      acc      <= 16'h0000;
      cf       <= 1'b0;
      cnt      <= 5'd0;
      result   <= 16'h0000;
      cf_out   <= 1'b0;
      of_out   <= 1'b0;
      flags_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_r  <= mode;
            bit16_r <= bit16;
            acc     <= operand_m;
            cf      <= cf_in;
            cnt     <= count[4:0];
            if (count_zero) begin
              state    <= FIN;
              result   <= operand_m;
              cf_out   <= cf_in;
              of_out   <= 1'b0;
              flags_we <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= step_acc;
          cf  <= step_cf;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state    <= FIN;
            result   <= step_acc;
            cf_out   <= step_cf;
            of_out   <= step_of;
            flags_we <= 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
- Multi-count shift/rotate sequencer for the x86 group-2 opcodes (D0–D3, C0/C1) with a count from CL or imm8.
- Iterates the single-bit shift/rotate operations of the combinational ALU (codes 8h–Fh) once per clock.
- Drives the ALU operand, op and carry inputs and takes the ALU result back each step.
- Tracks CF/OF itself and hands the final value and flags to writeback.

Parameters:
- none

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch request; honoured only when busy=0
- mode  in  3  0 ROL, 1 ROR, 2 RCL, 3 RCR, 4 SHL, 5 SHR, 6 SHL (alias), 7 SAR
- bit16  in  1  1 = word operand, 0 = byte operand
- operand  in  16  value to shift; bits [15:8] ignored when bit16=0
- count  in  8  raw shift count
- cf_in  in  1  current CF
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- result  out  16  final value; [15:8]=0 in byte mode
- cf_out  out  1  final CF
- of_out  out  1  final OF
- flags_we  out  1  valid with done; 1 = write CF/OF
- alu_op  out  4  to ALU alu port, = {1'b1, mode}
- alu_a  out  16  to ALU op1, = working register acc
- alu_bit16  out  1  to ALU bit16, = latched bit16
- alu_cf  out  1  to ALU flags[0], = running CF register
- alu_res  in  16  from ALU result

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset has priority over everything.
  - On reset, go to IDLE and clear busy, done, flags_we, result, cf_out, of_out, acc and cnt to 0. Abandon any in-flight sequence with no done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - busy=0.
  - On start, latch mode, bit16, acc=operand (upper byte zeroed if byte mode), cf=cf_in, cnt=count & 5'h1F.
  - If cnt==0, go to FIN. Otherwise go to RUN and set busy=1.
- RUN, one ALU step per cycle:
  - acc <= alu_res (masked to [7:0] in byte mode).
  - cnt <= cnt-1.
  - cf <= bit leaving the operand:
    - ROL, RCL, SHL: old acc MSB (bit 7 or 15).
    - ROR, RCR, SHR, SAR: old acc[0].
  - On the step where cnt==1, also compute OF from the new acc (msb = new MSB, msb1 = next bit down, oldmsb = old MSB):
    - ROL, RCL, SHL: msb^newCF.
    - ROR, RCR: msb^msb1.
    - SHR: oldmsb.
    - SAR: 0.
    - This rule applies for every count, including count>1.
  - Then go to FIN.
- FIN, one cycle:
  - done=1, busy=1.
  - result=acc, cf_out=cf.
  - For a zero count: flags_we=0, result=operand, cf_out=cf_in, of_out=0.
  - For a non-zero count: flags_we=1 and of_out=the computed OF.
  - Next state is IDLE.
- Hold: result, cf_out, of_out and flags_we hold after FIN until the next start or reset. done is 0 outside FIN.
- Latency: done is asserted exactly (masked count)+1 cycles after the start edge, i.e. 1 to 32 cycles.
- start while busy=1 (RUN or FIN) is ignored. No queuing.
- Count wrap:
  - Counts above 31 are reduced mod 32 before iterating (e.g. 0x21 gives 1 step).
  - RCL/RCR byte counts are not reduced mod 9; plain iteration yields the x86 result.
- A count greater than the operand width is legal: shifts saturate naturally, SAR fills with the sign.
- The alu_* outputs are valid in every state. The ALU is combinational, so alu_res is sampled in the same cycle.

Test Plan:
1. SHL byte, operand=0x0081, count=1, cf_in=0 → done 2 cycles after start; result=0x0002, cf_out=1, of_out=1, flags_we=1.
2. ROR word, operand=0x0001, count=4 → done at cycle 5; result=0x1000, cf_out=0, of_out=0; busy high cycles 1–5.
3. RCL byte, operand=0x80, count=9, cf_in=0 → result=0x0080, cf_out=0 (9-bit identity); done at cycle 10.
4. count=0x20 (masks to 0), ROL word operand=0x1234, cf_in=1 → done at cycle 1; result=0x1234, cf_out=1, of_out=0, flags_we=0. Also count=0x21 → exactly 1 step, result=0x2468.
5. SAR word, operand=0x8000, count=15 → result=0xFFFF, cf_out=0, of_out=0; SHR word same inputs → result=0x0001, cf_out=0, of_out=0.
6. Reset control:
   - Start SHL word count=31, assert reset at cycle 10 → next cycle busy=0, done=0, result=0; no done pulse ever appears.
   - A second start pulse issued while busy → ignored; the original result arrives on schedule.
